// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared state encoding, LED codes and helpers for tl_request_ctrl
package tl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WALK      = 3'd2,
        ST_LOCKOUT   = 3'd3,
        ST_EMERG     = 3'd4,
        ST_EMERG_CLR = 3'd5
    } tl_req_state_t;

    localparam logic [2:0] LED_GREEN  = 3'b100;
    localparam logic [2:0] LED_YELLOW = 3'b010;
    localparam logic [2:0] LED_RED    = 3'b001;
    localparam logic [2:0] LED_OFF    = 3'b000;

    function automatic int tl_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tl_debouncer.sv
// rtl/tl_debouncer.sv - 2-flop synchroniser followed by a stable-count debouncer
module tl_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] stable_cnt;

    // Synchronise the raw input, then flip the output only after the
    // synchronised value has disagreed with it for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            stable_cnt <= '0;
            dout       <= 1'b0;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            if (sync_2 == dout) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                dout       <= sync_2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl_request_ctrl.sv
// rtl/tl_request_ctrl.sv - pedestrian/emergency/night request sequencer; optional TL_REQ_TIMEOUT_EN red-confirm timeout
module tl_request_ctrl
    import tl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PED_WALK        = 8,
    parameter int PED_GAP         = 16,
    parameter int EMERG_CLEAR     = 4,
    parameter int REQ_TIMEOUT     = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_btn,
    input  logic       emerg_req,
    input  logic       night_sw,
    input  logic [2:0] leds_in,
    output logic       force_red,
    output logic       attention,
    output logic       walk,
    output logic       ped_pending,
    output logic       fault
);

    localparam int CNT_MAX = tl_max(tl_max(PED_WALK, PED_GAP), tl_max(EMERG_CLEAR, REQ_TIMEOUT));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LD_WALK  = CNT_W'(PED_WALK - 1);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(PED_GAP - 1);
    localparam logic [CNT_W-1:0] LD_CLEAR = CNT_W'(EMERG_CLEAR - 1);
    localparam logic [CNT_W-1:0] LD_REQ   = CNT_W'(REQ_TIMEOUT - 1);

    logic             ped_db;
    logic             emerg_db;
    logic             night_db;
    logic             ped_db_q;
    logic             ped_rise;
    logic             pend_now;
    logic             pend_nxt;
    logic             fault_set;
    tl_req_state_t    state;
    tl_req_state_t    state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    tl_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ped (
        .clk(clk), .rst(rst), .din(ped_btn), .dout(ped_db)
    );
    tl_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_emerg (
        .clk(clk), .rst(rst), .din(emerg_req), .dout(emerg_db)
    );
    tl_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_night (
        .clk(clk), .rst(rst), .din(night_sw), .dout(night_db)
    );

    assign ped_rise = ped_db & ~ped_db_q;
    // A press arriving this cycle counts as pending for this cycle's decisions.
    assign pend_now = ped_pending | ped_rise;

    // Next state, pending latch and countdown; emergency always wins.
    always_comb begin
        state_nxt = state;
        fault_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (emerg_db)      state_nxt = ST_EMERG;
                else if (pend_now) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (emerg_db)                state_nxt = ST_EMERG;
                else if (leds_in == LED_RED) state_nxt = ST_WALK;
`ifdef TL_REQ_TIMEOUT_EN
                else if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                    fault_set = 1'b1;
                end
`endif
            end
            ST_WALK: begin
                if (emerg_db)       state_nxt = ST_EMERG;
                else if (cnt == '0) state_nxt = ST_LOCKOUT;
            end
            ST_LOCKOUT: begin
                if (emerg_db)       state_nxt = ST_EMERG;
                else if (cnt == '0) state_nxt = ST_IDLE;
            end
            ST_EMERG: begin
                if (!emerg_db) state_nxt = ST_EMERG_CLR;
            end
            ST_EMERG_CLR: begin
                if (emerg_db)       state_nxt = ST_EMERG;
                else if (cnt == '0) state_nxt = pend_now ? ST_REQ : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // An interrupted walk owes the pedestrian another crossing.
        if (state_nxt == ST_WALK && state != ST_WALK)       pend_nxt = 1'b0;
        else if (state == ST_WALK && state_nxt == ST_EMERG) pend_nxt = 1'b1;
        else                                                 pend_nxt = pend_now;

        cnt_nxt = cnt;
        if (state_nxt != state) begin
            case (state_nxt)
                ST_REQ:       cnt_nxt = LD_REQ;
                ST_WALK:      cnt_nxt = LD_WALK;
                ST_LOCKOUT:   cnt_nxt = LD_GAP;
                ST_EMERG_CLR: cnt_nxt = LD_CLEAR;
                default:      cnt_nxt = '0;
            endcase
        end else if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
        end
    end

    // State, counter and outputs registered from the next-state decision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            ped_db_q    <= 1'b0;
            ped_pending <= 1'b0;
            force_red   <= 1'b0;
            attention   <= 1'b0;
            walk        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ped_db_q    <= ped_db;
            ped_pending <= pend_nxt;
            force_red   <= (state_nxt == ST_REQ) || (state_nxt == ST_WALK) ||
                           (state_nxt == ST_EMERG) || (state_nxt == ST_EMERG_CLR);
            attention   <= night_db && ((state_nxt == ST_IDLE) || (state_nxt == ST_LOCKOUT));
            walk        <= (state_nxt == ST_WALK);
        end
    end

`ifdef TL_REQ_TIMEOUT_EN
    // Sticky red-confirm timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           fault <= 1'b0;
        else if (fault_set) fault <= 1'b1;
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_tl_request_ctrl.sv
// tb/tb_tl_request_ctrl.sv - directed scoreboard bench for tl_request_ctrl
module tb_tl_request_ctrl;

    logic       clk;
    logic       rst;
    logic       ped_btn;
    logic       emerg_req;
    logic       night_sw;
    logic [2:0] leds_in;
    logic       force_red;
    logic       attention;
    logic       walk;
    logic       ped_pending;
    logic       fault;

    localparam logic [2:0] GREEN = 3'b100;
    localparam logic [2:0] RED   = 3'b001;

    typedef struct {
        string      tag;
        logic [4:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    tl_request_ctrl dut (
        .clk(clk), .rst(rst), .ped_btn(ped_btn), .emerg_req(emerg_req),
        .night_sw(night_sw), .leds_in(leds_in), .force_red(force_red),
        .attention(attention), .walk(walk), .ped_pending(ped_pending), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [4:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // Observed vector: {force_red, attention, walk, ped_pending, fault}
    task automatic check_pop();
        exp_t       e;
        logic [4:0] obs;
        e   = sb.pop_front();
        obs = {force_red, attention, walk, ped_pending, fault};
        checks++;
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
        end
        checks++;
        assert ((force_red & attention) === 1'b0) else begin
            errors++;
            $error("FAIL %s_excl: observed force_red=%b attention=%b expected not both 1",
                   e.tag, force_red, attention);
        end
    endtask

    task automatic run(input string tag, input logic [4:0] exp, input int n);
        for (int i = 0; i < n; i++) push_exp(tag, exp);
        for (int i = 0; i < n; i++) begin
            step();
            check_pop();
        end
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        ped_btn   = 1'b0;
        emerg_req = 1'b0;
        night_sw  = 1'b0;
        leds_in   = GREEN;
        run("reset", 5'b00000, 2);
        rst = 1'b1;
    endtask

    initial begin
        // Pedestrian cycle, lockout length, async reset mid-walk
        do_reset();
        ped_btn = 1'b1;
        run("ped_wait", 5'b00000, 6);
        run("ped_req", 5'b10010, 4);
        ped_btn = 1'b0;
        run("req_hold", 5'b10010, 10);
        leds_in = RED;
        run("walk", 5'b10100, 8);
        run("lockout", 5'b00000, 1);
        ped_btn = 1'b1;
        run("lock_press", 5'b00000, 6);
        run("lock_latch", 5'b00010, 4);
        ped_btn = 1'b0;
        run("lock_latch", 5'b00010, 6);
        run("req_after_gap", 5'b10010, 1);
        run("walk2", 5'b10100, 2);
        #2 rst = 1'b0;
        #1 push_exp("async_rst", 5'b00000);
        check_pop();
        step();
        rst = 1'b1;
        run("post_rst_idle", 5'b00000, 8);

        // Two-cycle glitch must be filtered
        do_reset();
        ped_btn = 1'b1;
        run("glitch", 5'b00000, 2);
        ped_btn = 1'b0;
        run("glitch", 5'b00000, 10);

        // Emergency during walk
        do_reset();
        leds_in = RED;
        ped_btn = 1'b1;
        run("ew_wait", 5'b00000, 6);
        run("ew_req", 5'b10010, 1);
        run("ew_walk", 5'b10100, 1);
        ped_btn   = 1'b0;
        emerg_req = 1'b1;
        run("ew_walk", 5'b10100, 6);
        run("ew_emerg", 5'b10010, 6);
        emerg_req = 1'b0;
        run("ew_hold", 5'b10010, 11);
        run("ew_rewalk", 5'b10100, 1);

        // Emergency from idle, no pedestrian
        do_reset();
        emerg_req = 1'b1;
        run("ei_wait", 5'b00000, 6);
        run("ei_emerg", 5'b10000, 4);
        emerg_req = 1'b0;
        run("ei_hold", 5'b10000, 10);
        run("ei_idle", 5'b00000, 3);

        // Simultaneous ped and emergency edges
        do_reset();
        leds_in   = RED;
        ped_btn   = 1'b1;
        emerg_req = 1'b1;
        run("sim_wait", 5'b00000, 6);
        run("sim_emerg", 5'b10010, 1);
        ped_btn   = 1'b0;
        emerg_req = 1'b0;
        run("sim_hold", 5'b10010, 11);
        run("sim_walk", 5'b10100, 1);

        // Night mode attention
        do_reset();
        night_sw = 1'b1;
        run("nt_wait", 5'b00000, 6);
        run("nt_attn", 5'b01000, 2);
        ped_btn = 1'b1;
        run("nt_attn", 5'b01000, 6);
        run("nt_req", 5'b10010, 1);
        ped_btn = 1'b0;
        leds_in = RED;
        run("nt_walk", 5'b10100, 8);
        run("nt_lock", 5'b01000, 16);
        run("nt_idle", 5'b01000, 2);

        // Red never confirmed
        do_reset();
        ped_btn = 1'b1;
        run("to_wait", 5'b00000, 6);
        run("to_req", 5'b10010, 4);
        ped_btn = 1'b0;
        run("to_req", 5'b10010, 60);
`ifdef TL_REQ_TIMEOUT_EN
        run("to_fault", 5'b00011, 1);
        run("to_retry", 5'b10011, 2);
`else
        run("to_nofault", 5'b10010, 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tl_request_ctrl.md
Name: tl_request_ctrl

Overview:
- Upstream stage of traffic_light: turns raw field inputs into the light's attention and force_red controls.
- Raw field inputs are the pedestrian button, the emergency-vehicle request and the night-mode switch.
- Synchronises and debounces each input, sequences pedestrian crossings, and holds the light red for emergency vehicles.
- Watches the light's leds output to confirm red before granting walk.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles before a debounced input changes.
- PED_WALK, 8: cycles walk stays high once red is confirmed.
- PED_GAP, 16: lockout cycles after a walk before the next pedestrian service.
- EMERG_CLEAR, 4: cycles force_red stays high after the emergency request drops.
- REQ_TIMEOUT, 64: max cycles waiting for red (optional feature only).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- ped_btn  input  1  raw pedestrian button, asynchronous.
- emerg_req  input  1  raw emergency request, asynchronous, level.
- night_sw  input  1  raw night-mode switch, asynchronous, level.
- leds_in  input  3  light state fed back from traffic_light; 3'b001 = red.
- force_red  output  1  to traffic_light force_red.
- attention  output  1  to traffic_light attention.
- walk  output  1  pedestrian walk lamp.
- ped_pending  output  1  pedestrian request latched, not yet served.
- fault  output  1  red-confirm timeout flag (optional feature).

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; debouncers and counters cleared.
- Input conditioning
  - Each raw input passes a 2-flop synchroniser, then a debouncer.
  - Debounced output toggles when the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Latency from raw edge to debounced edge = 2 + DEBOUNCE_CYCLES cycles.
- Pedestrian latch
  - A rising edge of debounced ped sets ped_pending, from any state.
  - One-deep: further presses while pending are ignored.
  - Cleared on entry to WALK.
- FSM states: IDLE, REQ, WALK, LOCKOUT, EMERG, EMERG_CLR.
  - IDLE: emerg -> EMERG; else if ped_pending -> REQ.
  - REQ: force_red=1.
    - emerg -> EMERG.
    - else if leds_in==3'b001 -> WALK, counter loaded PED_WALK-1.
  - WALK: force_red=1, walk=1; counter decrements.
    - emerg -> EMERG; walk drops the same cycle and ped_pending is re-set.
    - counter==0 -> LOCKOUT, counter loaded PED_GAP-1.
  - LOCKOUT: outputs 0; presses latch only.
    - emerg -> EMERG.
    - counter==0 -> IDLE.
  - EMERG: force_red=1 while debounced emerg is high.
    - emerg falls -> EMERG_CLR, counter loaded EMERG_CLEAR-1.
  - EMERG_CLR: force_red=1.
    - emerg re-asserts -> EMERG.
    - counter==0 -> REQ if ped_pending, else IDLE. No lockout is applied.
- attention = debounced night AND state in {IDLE, LOCKOUT}.
  - attention and force_red are never both 1.
- All outputs are registered: they change one cycle after the state or condition update.
- Simultaneous events
  - Emergency beats pedestrian.
  - A ped edge in the same cycle as an emerg edge still latches ped_pending.
- Counters are $clog2(max param + 1) bits, count down, and do not wrap; a parameter value of 1 gives a single-cycle state.

Optional Feature:
- Macro: TL_REQ_TIMEOUT_EN.
- Defined:
  - REQ counts cycles. If red is not seen within REQ_TIMEOUT cycles -> IDLE with ped_pending kept.
  - fault sets (sticky) and is cleared only by reset.
- Undefined: REQ waits indefinitely; fault tied 0.

Decomposition:
- Package tl_pkg holds:
  - State enum tl_req_state_t.
  - LED encoding constants LED_GREEN=3'b100, LED_YELLOW=3'b010, LED_RED=3'b001, LED_OFF=3'b000.
- Sub-module tl_debouncer (synchroniser + stable counter, parameter DEBOUNCE_CYCLES), instantiated three times.

Test Plan:
- Reset mid-WALK (rst low asynchronously) -> all outputs 0 the same cycle; state IDLE after release.
- ped_btn high 10 cycles, leds_in green; set leds_in=3'b001 at cycle 20:
  - force_red rises 7 cycles after press.
  - walk high for 8 cycles starting 1 cycle after red.
  - Then 16 cycles LOCKOUT, then IDLE.
- ped_btn glitch of 2 cycles -> no ped_pending, no force_red.
- emerg_req high during WALK:
  - walk drops.
  - force_red held through emergency plus 4 cycles.
  - Then REQ re-entered because ped_pending was re-set.
- night_sw high in IDLE -> attention=1; ped press -> attention 0 while force_red=1, attention returns in LOCKOUT.
- With TL_REQ_TIMEOUT_EN, leds_in held green after ped press -> fault=1 after 64 REQ cycles, state IDLE, ped_pending=1.
